cpu_controller_mc: RTL and testbench
====================================

Name: cpu_controller_mc

Overview:
Multi-cycle control FSM for the 16-bit CPU datapath. It adds configurable memory wait states, multi-cycle multiply, an external stall, and illegal-opcode detection to the two-state FETCH/EXECUTE controller. It decodes opcode/opcode_ext into datapath enables and selects, and all architectural writes happen in one final cycle per instruction.

Parameters:
MEM_WAIT_CYCLES, 1, cycles between presenting an address and read data valid (fetch and LOAD); legal range 0..15
MUL_CYCLES, 2, extra EXECUTE-side cycles for MUL/MULI before write-back; legal range 0..15
CNT_WIDTH, 16, width of the retired-instruction counter (optional feature only)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  4  instruction[15:12] from the instruction register
opcode_ext  in  4  instruction[7:4]
cmp_result  in  1  condition evaluation for Bcond/Jcond
stall  in  1  hold request from the memory/IO side
reg_wr_en  out  1  register file write
alu_src  out  1  0 = Rsrc, 1 = immediate
alu_sel  out  4  ALU function: ADD0 SUB1 AND2 OR3 XOR4 NOT5 LSH6 ASH7 MUL8
next_instr  out  1  memory address mux selects PC
pc_en  out  1  PC update
instr_en  out  1  instruction register load
cmp_f_en, of_f_en, z_f_en  out  1 each  flag register enables
pc_addr_mode  out  2  0 = increment, 1 = offset, 2 = absolute
write_back_sel  out  3  0 = ALU, 1 = MEM, 2 = REG, 3 = IMM, 4 = PC
mem_wr_en  out  1  memory write
illegal_op  out  1  one-cycle pulse on an undefined opcode or extension
state_out  out  3  current state, for debug

Behaviour:
- States: FETCH = 0, FETCH_WAIT = 1, EXECUTE = 2, MEM_WAIT = 3, MUL_WAIT = 4. One 4-bit wait counter is shared by the wait states.
- Reset (asynchronous): state = FETCH, wait counter = MEM_WAIT_CYCLES. All outputs are 0, except next_instr = 1 (it is combinational from FETCH).
- FETCH:
  - next_instr = 1.
  - If MEM_WAIT_CYCLES = 0: instr_en = 1, go to EXECUTE.
  - Otherwise go to FETCH_WAIT with counter = MEM_WAIT_CYCLES - 1.
- FETCH_WAIT:
  - next_instr = 1.
  - Counter decrements each cycle. When counter = 0: instr_en = 1, go to EXECUTE.
  - Fetch latency is MEM_WAIT_CYCLES + 1 cycles.
- EXECUTE decode:
  - Single-cycle classes assert all writes this cycle, plus pc_en = 1, then go to FETCH.
    - ALU reg/reg and immediate: AND/OR/XOR(I) set z; ADD(I) sets z, of; SUB(I) sets z, of, cmp; CMP(I) sets z, cmp with no reg write.
    - MOV: write_back_sel = REG. MOVI: IMM. LUI: IMM, z. Shifts: alu_src = 1 for LSHI/ASHUI.
    - STOR: mem_wr_en = 1, next_instr = 0.
    - JAL: write_back_sel = PC, pc_addr_mode = 2. Jcond: mode = cmp_result ? 2 : 0. Bcond: mode = cmp_result ? 1 : 0.
  - LOAD: next_instr = 0.
    - If MEM_WAIT_CYCLES = 0, write immediately: write_back_sel = MEM, reg_wr_en = 1, pc_en = 1.
    - Otherwise go to MEM_WAIT with counter = MEM_WAIT_CYCLES - 1.
  - MUL/MULI: alu_sel = MUL.
    - If MUL_CYCLES = 0, write in EXECUTE with z_f_en = 1.
    - Otherwise go to MUL_WAIT with counter = MUL_CYCLES - 1.
- MEM_WAIT / MUL_WAIT:
  - alu_sel, alu_src, next_instr and write_back_sel are held at their decoded values.
  - On counter = 0, the final-cycle writes and pc_en = 1 assert, then go to FETCH.
- Illegal opcodes (0110, 0111, 1010, and undefined extensions of 0000/0100/1000):
  - illegal_op = 1, pc_en = 1 with mode 0, no reg/mem/flag writes, go to FETCH.
- stall = 1, in any state:
  - State and counter hold.
  - reg_wr_en, pc_en, instr_en, mem_wr_en, all flag enables and illegal_op are forced to 0.
  - Muxes keep their values. The suppressed action reissues on the first cycle with stall = 0.
- reset mid-instruction: returns to FETCH immediately; no partial write is ever issued.
- Every write enable is high for at most one cycle per instruction.
- Decode inputs are sampled combinationally. opcode and opcode_ext must stay stable from EXECUTE until the final write cycle (they do, because the IR only loads on instr_en).

Optional Feature:
CPU_CTRL_PERF_CNT_EN:
- Defined: adds output instr_count [CNT_WIDTH-1:0].
- It resets to 0 and increments on every cycle where pc_en = 1, including illegal ops, and wraps to 0 after all-ones.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- MEM_WAIT_CYCLES = 2, release reset → next_instr = 1 for 3 cycles, instr_en = 1 only on cycle 3, state_out = 2 on cycle 4.
- ADD reg/reg (op 0000, ext 0101) → one EXECUTE cycle with reg_wr_en = 1, z_f_en = 1, of_f_en = 1, cmp_f_en = 0, alu_sel = 0, pc_en = 1, pc_addr_mode = 0.
- LOAD (0100/0000), MEM_WAIT_CYCLES = 2 → EXECUTE then 2 MEM_WAIT cycles; reg_wr_en = 1 with write_back_sel = 1 only in the last one; next_instr = 0 throughout.
- MULI (1110), MUL_CYCLES = 3 → alu_sel = 8 and alu_src = 1 for 4 cycles; reg_wr_en and z_f_en high only on the 4th.
- Bcond with cmp_result = 1, then with cmp_result = 0 → pc_addr_mode = 1, then 0; Jcond with cmp_result = 1 → 2; JAL → write_back_sel = 4, mode = 2.
- Opcode 0110 → illegal_op one pulse, no writes. stall = 1 for 5 cycles during STOR EXECUTE → mem_wr_en = 0 during stall, then exactly 1 cycle high. With CPU_CTRL_PERF_CNT_EN, instr_count = 2 afterwards.

Source files
------------

// File: rtl/cpu_controller_mc.sv
// Multi-cycle FETCH/EXECUTE controller for the 16-bit CPU: memory wait states, multi-cycle MUL, stall, illegal-op trap.
// Optional retired-instruction counter enabled by `define CPU_CTRL_PERF_CNT_EN (adds output instr_count).
module cpu_controller_mc #(
  parameter int unsigned MEM_WAIT_CYCLES = 1,
  parameter int unsigned MUL_CYCLES      = 2,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic [3:0] opcode_ext,
  input  logic       cmp_result,
  input  logic       stall,
  output logic       reg_wr_en,
  output logic       alu_src,
  output logic [3:0] alu_sel,
  output logic       next_instr,
  output logic       pc_en,
  output logic       instr_en,
  output logic       cmp_f_en,
  output logic       of_f_en,
  output logic       z_f_en,
  output logic [1:0] pc_addr_mode,
  output logic [2:0] write_back_sel,
  output logic       mem_wr_en,
  output logic       illegal_op,
  output logic [2:0] state_out
`ifdef CPU_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] instr_count
`endif
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] MEM_WAIT_RST  = CW'(MEM_WAIT_CYCLES);
  localparam logic [CW-1:0] MEM_WAIT_INIT = (MEM_WAIT_CYCLES == 0) ? '0 : CW'(MEM_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] MUL_INIT      = (MUL_CYCLES == 0) ? '0 : CW'(MUL_CYCLES - 1);

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                         ALU_XOR = 4'd4, ALU_NOT = 4'd5, ALU_LSH = 4'd6, ALU_ASH = 4'd7,
                         ALU_MUL = 4'd8;
  localparam logic [2:0] WB_ALU = 3'd0, WB_MEM = 3'd1, WB_REG = 3'd2, WB_IMM = 3'd3, WB_PC = 3'd4;
  localparam logic [1:0] PC_INC = 2'd0, PC_OFF = 2'd1, PC_ABS = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH      = 3'd0,
    S_FETCH_WAIT = 3'd1,
    S_EXECUTE    = 3'd2,
    S_MEM_WAIT   = 3'd3,
    S_MUL_WAIT   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  logic       dec_reg_wr, dec_alu_src, dec_cmp, dec_of, dec_z, dec_mem_wr;
  logic       dec_load, dec_mul, dec_illegal;
  logic [3:0] dec_alu_sel, alu_code;
  logic [2:0] dec_wb;
  logic [1:0] dec_mode;

  logic instr_en_raw, final_raw, illegal_raw, go;

  // Instruction decode: what the final (architectural write) cycle looks like
  always_comb begin
    dec_reg_wr  = 1'b1;
    dec_alu_src = (opcode != 4'b0000);
    dec_alu_sel = ALU_ADD;
    dec_wb      = WB_ALU;
    dec_cmp     = 1'b0;
    dec_of      = 1'b0;
    dec_z       = 1'b0;
    dec_mem_wr  = 1'b0;
    dec_mode    = PC_INC;
    dec_load    = 1'b0;
    dec_mul     = 1'b0;
    dec_illegal = 1'b0;
    alu_code    = (opcode == 4'b0000) ? opcode_ext : opcode;

    case (opcode)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0101,
      4'b1001, 4'b1011, 4'b1101, 4'b1110: begin
        // Register form uses the extension field, immediate form the opcode itself
        case (alu_code)
          4'b0001: begin dec_alu_sel = ALU_AND; dec_z = 1'b1; end
          4'b0010: begin dec_alu_sel = ALU_OR;  dec_z = 1'b1; end
          4'b0011: begin dec_alu_sel = ALU_XOR; dec_z = 1'b1; end
          4'b0100: begin dec_alu_sel = ALU_NOT; dec_z = 1'b1; end
          4'b0101: begin dec_alu_sel = ALU_ADD; dec_z = 1'b1; dec_of = 1'b1; end
          4'b1001: begin dec_alu_sel = ALU_SUB; dec_z = 1'b1; dec_of = 1'b1; dec_cmp = 1'b1; end
          4'b1011: begin dec_alu_sel = ALU_SUB; dec_z = 1'b1; dec_cmp = 1'b1; dec_reg_wr = 1'b0; end
          4'b1101: dec_wb = (opcode == 4'b0000) ? WB_REG : WB_IMM;
          4'b1110: begin dec_alu_sel = ALU_MUL; dec_z = 1'b1; dec_mul = 1'b1; end
          default: dec_illegal = 1'b1;
        endcase
      end
      4'b1111: begin dec_wb = WB_IMM; dec_z = 1'b1; end
      4'b1100: begin
        dec_alu_src = 1'b0;
        dec_reg_wr  = 1'b0;
        dec_mode    = cmp_result ? PC_OFF : PC_INC;
      end
      4'b0100: begin
        dec_alu_src = 1'b0;
        case (opcode_ext)
          4'b0000: begin dec_wb = WB_MEM; dec_load = 1'b1; end
          4'b0100: begin dec_reg_wr = 1'b0; dec_mem_wr = 1'b1; end
          4'b1000: begin dec_wb = WB_PC; dec_mode = PC_ABS; end
          4'b1100: begin dec_reg_wr = 1'b0; dec_mode = cmp_result ? PC_ABS : PC_INC; end
          default: dec_illegal = 1'b1;
        endcase
      end
      4'b1000: begin
        case (opcode_ext)
          4'b0100: begin dec_alu_src = 1'b0; dec_alu_sel = ALU_LSH; end
          4'b0000: begin dec_alu_src = 1'b1; dec_alu_sel = ALU_LSH; end
          4'b0110: begin dec_alu_src = 1'b0; dec_alu_sel = ALU_ASH; end
          4'b0010: begin dec_alu_src = 1'b1; dec_alu_sel = ALU_ASH; end
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase

    if (dec_illegal) begin
      dec_reg_wr  = 1'b0;
      dec_alu_src = 1'b0;
      dec_alu_sel = ALU_ADD;
      dec_wb      = WB_ALU;
      dec_cmp     = 1'b0;
      dec_of      = 1'b0;
      dec_z       = 1'b0;
      dec_mem_wr  = 1'b0;
      dec_mode    = PC_INC;
      dec_load    = 1'b0;
      dec_mul     = 1'b0;
    end
  end

  // Next state, wait counter and mux outputs; enables are raw here and gated below
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    next_instr     = 1'b0;
    alu_src        = 1'b0;
    alu_sel        = ALU_ADD;
    write_back_sel = WB_ALU;
    pc_addr_mode   = PC_INC;
    instr_en_raw   = 1'b0;
    final_raw      = 1'b0;
    illegal_raw    = 1'b0;

    case (state_q)
      S_FETCH: begin
        next_instr = 1'b1;
        if (MEM_WAIT_CYCLES == 0) begin
          instr_en_raw = 1'b1;
          state_d      = S_EXECUTE;
        end else begin
          state_d    = S_FETCH_WAIT;
          wait_cnt_d = MEM_WAIT_INIT;
        end
      end
      S_FETCH_WAIT: begin
        next_instr = 1'b1;
        if (wait_cnt_q == '0) begin
          instr_en_raw = 1'b1;
          state_d      = S_EXECUTE;
        end else begin
          wait_cnt_d = wait_cnt_q - CW'(1);
        end
      end
      S_EXECUTE: begin
        alu_src        = dec_alu_src;
        alu_sel        = dec_alu_sel;
        write_back_sel = dec_wb;
        pc_addr_mode   = dec_mode;
        if (dec_illegal) begin
          illegal_raw = 1'b1;
          state_d     = S_FETCH;
        end else if (dec_load && (MEM_WAIT_CYCLES != 0)) begin
          state_d    = S_MEM_WAIT;
          wait_cnt_d = MEM_WAIT_INIT;
        end else if (dec_mul && (MUL_CYCLES != 0)) begin
          state_d    = S_MUL_WAIT;
          wait_cnt_d = MUL_INIT;
        end else begin
          final_raw = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_MEM_WAIT, S_MUL_WAIT: begin
        alu_src        = dec_alu_src;
        alu_sel        = dec_alu_sel;
        write_back_sel = dec_wb;
        pc_addr_mode   = dec_mode;
        if (wait_cnt_q == '0) begin
          final_raw = 1'b1;
          state_d   = S_FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q - CW'(1);
        end
      end
      default: state_d = S_FETCH;
    endcase

    if (stall) begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
    end
  end

  // A stalled or reset cycle issues no writes; the action repeats once stall drops
  assign go         = ~stall & ~reset;
  assign instr_en   = go & instr_en_raw;
  assign reg_wr_en  = go & final_raw & dec_reg_wr;
  assign mem_wr_en  = go & final_raw & dec_mem_wr;
  assign cmp_f_en   = go & final_raw & dec_cmp;
  assign of_f_en    = go & final_raw & dec_of;
  assign z_f_en     = go & final_raw & dec_z;
  assign pc_en      = go & (final_raw | illegal_raw);
  assign illegal_op = go & illegal_raw;
  assign state_out  = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= MEM_WAIT_RST;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef CPU_CTRL_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] instr_count_q, instr_count_d;

  always_comb begin
    instr_count_d = instr_count_q;
    if (pc_en) instr_count_d = instr_count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) instr_count_q <= '0;
    else       instr_count_q <= instr_count_d;
  end

  assign instr_count = instr_count_q;
`else
  logic [CNT_WIDTH-1:0] unused_cnt_width;
  assign unused_cnt_width = '0;
`endif

endmodule

// File: tb/tb_cpu_controller_mc.sv
// Randomized bench for cpu_controller_mc: per-instruction expected output sequences built from mnemonic rules.
module tb_cpu_controller_mc;

  localparam int unsigned MW = 2;
  localparam int unsigned MC = 3;
  localparam int unsigned CNTW = 16;

  logic       clk, reset, cmp_result, stall;
  logic [3:0] opcode, opcode_ext;
  logic       reg_wr_en, alu_src, next_instr, pc_en, instr_en;
  logic       cmp_f_en, of_f_en, z_f_en, mem_wr_en, illegal_op;
  logic [3:0] alu_sel;
  logic [1:0] pc_addr_mode;
  logic [2:0] write_back_sel, state_out;
`ifdef CPU_CTRL_PERF_CNT_EN
  logic [CNTW-1:0] instr_count;
`endif

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  cpu_controller_mc #(.MEM_WAIT_CYCLES(MW), .MUL_CYCLES(MC), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .opcode_ext(opcode_ext),
    .cmp_result(cmp_result), .stall(stall), .reg_wr_en(reg_wr_en), .alu_src(alu_src),
    .alu_sel(alu_sel), .next_instr(next_instr), .pc_en(pc_en), .instr_en(instr_en),
    .cmp_f_en(cmp_f_en), .of_f_en(of_f_en), .z_f_en(z_f_en), .pc_addr_mode(pc_addr_mode),
    .write_back_sel(write_back_sel), .mem_wr_en(mem_wr_en), .illegal_op(illegal_op),
    .state_out(state_out)
`ifdef CPU_CTRL_PERF_CNT_EN
    , .instr_count(instr_count)
`endif
  );

  typedef struct packed {
    logic [2:0] st;
    logic       ni, ie, rw, as;
    logic [3:0] asel;
    logic [2:0] wb;
    logic [1:0] pm;
    logic       mw, pe, cf, of, zf, il;
  } obs_t;

  obs_t act;
  assign act = {state_out, next_instr, instr_en, reg_wr_en, alu_src, alu_sel, write_back_sel,
                pc_addr_mode, mem_wr_en, pc_en, cmp_f_en, of_f_en, z_f_en, illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string mnem(input logic [3:0] op, input logic [3:0] ext);
    case (op)
      4'h0: case (ext)
              4'h1: return "AND";  4'h2: return "OR";   4'h3: return "XOR";
              4'h4: return "NOT";  4'h5: return "ADD";  4'h9: return "SUB";
              4'hB: return "CMP";  4'hD: return "MOV";  4'hE: return "MUL";
              default: return "ILL";
            endcase
      4'h1: return "ANDI";
      4'h2: return "ORI";
      4'h3: return "XORI";
      4'h4: case (ext)
              4'h0: return "LOAD"; 4'h4: return "STOR"; 4'h8: return "JAL"; 4'hC: return "JCOND";
              default: return "ILL";
            endcase
      4'h5: return "ADDI";
      4'h8: case (ext)
              4'h4: return "LSH";  4'h0: return "LSHI"; 4'h6: return "ASH"; 4'h2: return "ASHUI";
              default: return "ILL";
            endcase
      4'h9: return "SUBI";
      4'hB: return "CMPI";
      4'hC: return "BCOND";
      4'hD: return "MOVI";
      4'hE: return "MULI";
      4'hF: return "LUI";
      default: return "ILL";
    endcase
  endfunction

  // kind: 0 single-cycle, 1 load, 2 multiply, 3 illegal
  function automatic obs_t final_of(input string m, input logic cmp, output int kind);
    obs_t f = '0;
    f.rw = 1'b1;
    kind = 0;
    case (m)
      "ANDI", "ORI", "XORI", "ADDI", "SUBI", "CMPI", "MOVI", "MULI", "LUI", "LSHI", "ASHUI": f.as = 1'b1;
      default: ;
    endcase
    case (m)
      "AND", "ANDI": begin f.asel = 4'd2; f.zf = 1'b1; end
      "OR", "ORI":   begin f.asel = 4'd3; f.zf = 1'b1; end
      "XOR", "XORI": begin f.asel = 4'd4; f.zf = 1'b1; end
      "NOT":         begin f.asel = 4'd5; f.zf = 1'b1; end
      "ADD", "ADDI": begin f.zf = 1'b1; f.of = 1'b1; end
      "SUB", "SUBI": begin f.asel = 4'd1; f.zf = 1'b1; f.of = 1'b1; f.cf = 1'b1; end
      "CMP", "CMPI": begin f.asel = 4'd1; f.zf = 1'b1; f.cf = 1'b1; f.rw = 1'b0; end
      "MOV":         f.wb = 3'd2;
      "MOVI":        f.wb = 3'd3;
      "LUI":         begin f.wb = 3'd3; f.zf = 1'b1; end
      "LSH", "LSHI": f.asel = 4'd6;
      "ASH", "ASHUI": f.asel = 4'd7;
      "MUL", "MULI": begin f.asel = 4'd8; f.zf = 1'b1; kind = 2; end
      "LOAD":        begin f.wb = 3'd1; kind = 1; end
      "STOR":        begin f.rw = 1'b0; f.mw = 1'b1; end
      "JAL":         begin f.wb = 3'd4; f.pm = 2'd2; end
      "JCOND":       begin f.rw = 1'b0; f.pm = cmp ? 2'd2 : 2'd0; end
      "BCOND":       begin f.rw = 1'b0; f.pm = cmp ? 2'd1 : 2'd0; end
      default:       begin f.as = 1'b0; f.rw = 1'b0; f.il = 1'b1; kind = 3; end
    endcase
    f.pe = 1'b1;
    return f;
  endfunction

  function automatic obs_t gated(input obs_t e);
    obs_t g = e;
    g.ie = 1'b0; g.rw = 1'b0; g.mw = 1'b0; g.pe = 1'b0;
    g.cf = 1'b0; g.of = 1'b0; g.zf = 1'b0; g.il = 1'b0;
    return g;
  endfunction

  function automatic obs_t reset_vec();
    obs_t r = '0;
    r.ni = 1'b1;
    return r;
  endfunction

  // Runs one instruction from FETCH to its final cycle; forced stall at step stall_step, random stalls at stall_pct %
  task automatic run_instr(input logic [3:0] op, input logic [3:0] ext, input logic cmp,
                           input int stall_step, input int stall_len, input int stall_pct);
    obs_t q[$];
    obs_t e, f;
    int kind, n_extra, idx, det, rnd, guard;
    string m;
    m = mnem(op, ext);
    f = final_of(m, cmp, kind);
    for (int i = 0; i <= int'(MW); i++) begin
      e = '0;
      e.st = (i == 0) ? 3'd0 : 3'd1;
      e.ni = 1'b1;
      e.ie = (i == int'(MW));
      q.push_back(e);
    end
    n_extra = (kind == 1) ? int'(MW) : (kind == 2) ? int'(MC) : 0;
    for (int j = 0; j <= n_extra; j++) begin
      e = f;
      e.st = (j == 0) ? 3'd2 : ((kind == 1) ? 3'd3 : 3'd4);
      if (j != n_extra) e = gated(e);
      q.push_back(e);
    end
    idx = 0; det = 0; rnd = 0; guard = 0;
    while (idx < q.size()) begin
      @(negedge clk);
      if (guard == 0) begin
        opcode = op; opcode_ext = ext; cmp_result = cmp;
      end
      if (idx == stall_step && det < stall_len) begin
        stall = 1'b1; det++;
      end else if (stall_pct > 0 && rnd < 8 && $urandom_range(0, 99) < stall_pct) begin
        stall = 1'b1; rnd++;
      end else begin
        stall = 1'b0;
      end
      #1;
      e = stall ? gated(q[idx]) : q[idx];
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s step %0d stall=%0b: got %h expected %h", m, idx, stall, act, e);
      end
      if (!stall) idx++;
      guard++;
      if (guard > q.size() + 40) begin
        bad++;
        $display("FAIL %s timeout: step %0d of %0d", m, idx, q.size());
        break;
      end
    end
    exp_cnt++;
  endtask

  task automatic check_count(input string tag);
`ifdef CPU_CTRL_PERF_CNT_EN
    #1;
    total++;
    if (instr_count !== CNTW'(exp_cnt)) begin
      bad++;
      $display("FAIL count %s: got %0d expected %0d", tag, instr_count, exp_cnt);
    end
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (act !== reset_vec()) begin
      bad++;
      $display("FAIL reset outputs: got %h expected %h", act, reset_vec());
    end
    exp_cnt = 0;
    check_count("reset");
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_illegal_stall();
    run_instr(4'b0110, 4'h0, 1'b0, -1, 0, 0);
    run_instr(4'b0100, 4'b0100, 1'b0, int'(MW) + 1, 5, 0);
    check_count("ill_stor");
  endtask

  task automatic test_directed();
    run_instr(4'b0000, 4'b0101, 1'b0, -1, 0, 0);
    run_instr(4'b0100, 4'b0000, 1'b0, -1, 0, 0);
    run_instr(4'b1110, 4'h7, 1'b0, -1, 0, 0);
    run_instr(4'b1100, 4'h3, 1'b1, -1, 0, 0);
    run_instr(4'b1100, 4'h3, 1'b0, -1, 0, 0);
    run_instr(4'b0100, 4'b1100, 1'b1, -1, 0, 0);
    run_instr(4'b0100, 4'b1000, 1'b0, -1, 0, 0);
    run_instr(4'b1000, 4'b0011, 1'b0, -1, 0, 0);
    check_count("directed");
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      run_instr(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                -1, 0, 25);
    end
    check_count("random");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    opcode = 4'b1110; opcode_ext = 4'h0; stall = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    total++;
    if (state_out !== 3'd4) begin
      bad++;
      $display("FAIL mid_state: got %0d expected 4", state_out);
    end
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (act !== reset_vec()) begin
        bad++;
        $display("FAIL mid_reset %0d: got %h expected %h", k, act, reset_vec());
      end
      @(negedge clk);
      #1;
    end
    exp_cnt = 0;
    check_count("mid_reset");
    @(posedge clk);
    #1 reset = 1'b0;
    run_instr(4'b0000, 4'b1001, 1'b0, -1, 0, 0);
    check_count("after_reset");
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; cmp_result = 1'b0;
    opcode = 4'h0; opcode_ext = 4'h0;
    test_reset();
    test_illegal_stall();
    test_directed();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
